board_dump: RTL and testbench

Serialises the 64-square board vector into an ASCII text stream, one character per square, for a UART transmitter or debug sink. Sits beside the display interface as a second reader of the packed board bus maintained by the top level. On a start pulse it snapshots the board, then emits ranks in address order over a valid/ready byte handshake. It signals completion with a one-cycle pulse.

---
 rtl/chess_pkg.sv | 34 +++
 rtl/board_dump_if.sv | 9 +
 rtl/board_dump_piece_to_ascii.sv | 27 ++
 rtl/board_dump.sv | 112 +++++++++++
 tb/tb_board_dump.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
// Shared chess encodings: piece codes, colours, ASCII glyphs and the dump FSM states.
package chess_pkg;

    localparam logic [2:0] PIECE_NONE   = 3'd0;
    localparam logic [2:0] PIECE_PAWN   = 3'd1;
    localparam logic [2:0] PIECE_KNIGHT = 3'd2;
    localparam logic [2:0] PIECE_BISHOP = 3'd3;
    localparam logic [2:0] PIECE_ROOK   = 3'd4;
    localparam logic [2:0] PIECE_QUEEN  = 3'd5;
    localparam logic [2:0] PIECE_KING   = 3'd6;

    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_P     = 8'h50;
    localparam logic [7:0] ASCII_N     = 8'h4E;
    localparam logic [7:0] ASCII_B     = 8'h42;
    localparam logic [7:0] ASCII_R     = 8'h52;
    localparam logic [7:0] ASCII_Q     = 8'h51;
    localparam logic [7:0] ASCII_K     = 8'h4B;
    localparam logic [7:0] ASCII_CASE  = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SQ,
        ST_CR,
        ST_LF
    } dump_state_e;

endpackage

// File: rtl/board_dump_if.sv
// Byte stream handshake from the board dumper to a UART or debug sink.
interface board_dump_if;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;

    modport master (output TX_DATA, output TX_VALID, input TX_READY);
    modport slave  (input TX_DATA, input TX_VALID, output TX_READY);
endinterface

// File: rtl/board_dump_piece_to_ascii.sv
// Maps a 4-bit square code {colour, piece} to its printable ASCII character.
module piece_to_ascii
    import chess_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [7:0] o_char
);

    logic [7:0] w_case;

    assign w_case = (i_code[3] == COLOR_BLACK) ? ASCII_CASE : 8'h00;

    always_comb begin
        o_char = ASCII_QMARK;
        case (i_code[2:0])
            PIECE_NONE:   o_char = ASCII_DOT;
            PIECE_PAWN:   o_char = ASCII_P | w_case;
            PIECE_KNIGHT: o_char = ASCII_N | w_case;
            PIECE_BISHOP: o_char = ASCII_B | w_case;
            PIECE_ROOK:   o_char = ASCII_R | w_case;
            PIECE_QUEEN:  o_char = ASCII_Q | w_case;
            PIECE_KING:   o_char = ASCII_K | w_case;
            default:      o_char = ASCII_QMARK;
        endcase
    end

endmodule

// File: rtl/board_dump.sv
// Snapshots the packed board on START and streams it as ASCII text, one byte per
// square in square order, optionally with CR/LF after each rank.
module board_dump
    import chess_pkg::*;
#(
    parameter bit NEWLINE_EN = 1'b1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [255:0]       BOARD,
    input  logic               START,
    board_dump_if.master       tx,
    output logic               BUSY,
    output logic               DONE
);

    dump_state_e r_state;
    logic [5:0]   r_sq;
    logic [255:0] r_snap;
    logic [7:0]   r_data;
    logic         r_valid;
    logic         r_busy;
    logic         r_done;

    logic [5:0]   w_sq_nxt;
    logic [3:0]   w_code;
    logic [7:0]   w_char;
    logic         w_accept;

    // The character is always prepared one square ahead: square 0 straight from
    // BOARD while idle, otherwise the next square of the snapshot.
    assign w_sq_nxt = r_sq + 6'd1;
    assign w_code   = (r_state == ST_IDLE) ? BOARD[3:0] : r_snap[{w_sq_nxt, 2'b00} +: 4];
    assign w_accept = r_valid && tx.TX_READY;

    piece_to_ascii u_p2a (
        .i_code (w_code),
        .o_char (w_char)
    );

    always_ff @(posedge CLK) begin
        if (r_state == ST_IDLE && START)
            r_snap <= BOARD;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_sq    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_state <= ST_SQ;
                        r_sq    <= '0;
                        r_data  <= w_char;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SQ: begin
                    if (w_accept) begin
                        if (NEWLINE_EN && r_sq[2:0] == 3'd7) begin
                            r_state <= ST_CR;
                            r_data  <= ASCII_CR;
                        end else if (r_sq == 6'd63) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_sq   <= w_sq_nxt;
                            r_data <= w_char;
                        end
                    end
                end
                ST_CR: begin
                    if (w_accept) begin
                        r_state <= ST_LF;
                        r_data  <= ASCII_LF;
                    end
                end
                ST_LF: begin
                    if (w_accept) begin
                        if (r_sq == 6'd63) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_SQ;
                            r_sq    <= w_sq_nxt;
                            r_data  <= w_char;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx.TX_DATA  = r_data;
    assign tx.TX_VALID = r_valid;
    assign BUSY        = r_busy;
    assign DONE        = r_done;

endmodule

// File: tb/tb_board_dump.sv
// Self-checking bench for board_dump: a text-level model of the expected stream is
// compared against both a newline and a no-newline instance every cycle.
module tb_board_dump;

    logic         CLK;
    logic         RESET_N;
    logic [255:0] BOARD;
    logic         start [2];
    logic         rdy   [2];
    logic         busy0, busy1, done0, done1;

    logic         d_valid [2];
    logic         d_busy  [2];
    logic         d_done  [2];
    logic [7:0]   d_data  [2];

    board_dump_if tx0 ();
    board_dump_if tx1 ();

    board_dump #(.NEWLINE_EN(1'b1)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .BOARD(BOARD), .START(start[0]),
        .tx(tx0.master), .BUSY(busy0), .DONE(done0)
    );
    board_dump #(.NEWLINE_EN(1'b0)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .BOARD(BOARD), .START(start[1]),
        .tx(tx1.master), .BUSY(busy1), .DONE(done1)
    );

    assign tx0.TX_READY = rdy[0];
    assign tx1.TX_READY = rdy[1];
    assign d_valid[0] = tx0.TX_VALID;
    assign d_valid[1] = tx1.TX_VALID;
    assign d_data[0]  = tx0.TX_DATA;
    assign d_data[1]  = tx1.TX_DATA;
    assign d_busy[0]  = busy0;
    assign d_busy[1]  = busy1;
    assign d_done[0]  = done0;
    assign d_done[1]  = done1;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_char(input logic [3:0] c);
        string letters;
        logic [7:0] b;
        letters = "PNBRQK";
        if (c[2:0] == 3'd0) return 8'h2E;
        if (c[2:0] == 3'd7) return 8'h3F;
        b = letters[int'(c[2:0]) - 1];
        return c[3] ? b + 8'h20 : b;
    endfunction

    // model state per instance
    bit         chk_en = 1'b0;
    bit         m_active [2] = '{1'b0, 1'b0};
    bit         m_done_pend [2] = '{1'b0, 1'b0};
    int         m_idx [2];
    int         m_len [2];
    logic [7:0] m_exp [2][80];
    logic [7:0] rx [2][80];
    int         rx_cnt [2] = '{0, 0};
    int         done_cnt [2] = '{0, 0};

    always @(negedge CLK) begin
        for (int u = 0; u < 2; u++) begin
            if (chk_en) begin
                if (m_active[u]) begin
                    chk("valid_active", int'(d_valid[u]), 1);
                    chk("busy_active", int'(d_busy[u]), 1);
                    chk("done_active", int'(d_done[u]), 0);
                    chk("data", int'(d_data[u]), int'(m_exp[u][m_idx[u]]));
                    if (RESET_N && rdy[u]) begin
                        if (rx_cnt[u] < 80) rx[u][rx_cnt[u]] = d_data[u];
                        rx_cnt[u]++;
                        m_idx[u]++;
                        if (m_idx[u] == m_len[u]) begin
                            m_active[u]    = 1'b0;
                            m_done_pend[u] = 1'b1;
                        end
                    end
                end else begin
                    chk("valid_idle", int'(d_valid[u]), 0);
                    chk("busy_idle", int'(d_busy[u]), 0);
                    chk("done", int'(d_done[u]), int'(m_done_pend[u]));
                    if (d_done[u]) done_cnt[u]++;
                    m_done_pend[u] = 1'b0;
                    if (RESET_N && start[u]) begin
                        int k;
                        k = 0;
                        for (int sq = 0; sq < 64; sq++) begin
                            m_exp[u][k] = m_char(BOARD[sq*4 +: 4]);
                            k++;
                            if (u == 0 && sq % 8 == 7) begin
                                m_exp[u][k] = 8'h0D;
                                m_exp[u][k+1] = 8'h0A;
                                k += 2;
                            end
                        end
                        m_len[u]    = k;
                        m_idx[u]    = 0;
                        m_active[u] = 1'b1;
                    end
                end
            end
            if (!RESET_N) begin
                m_active[u]    = 1'b0;
                m_done_pend[u] = 1'b0;
            end
        end
        if (!RESET_N) chk_en = 1'b1;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start(input int u);
        rx_cnt[u]   = 0;
        done_cnt[u] = 0;
        start[u] = 1'b1;
        step();
        start[u] = 1'b0;
    endtask

    task automatic run_until_idle(input int u, input bit rand_rdy);
        int c;
        c = 0;
        while ((m_active[u] || m_done_pend[u]) && c < 3000) begin
            if (rand_rdy) rdy[u] = 1'($urandom_range(0, 1));
            step();
            c++;
        end
        rdy[u] = 1'b1;
        chk("timeout_idle", int'(c < 3000), 1);
    endtask

    task automatic wait_rx(input int u, input int n);
        int c;
        c = 0;
        while (rx_cnt[u] != n && c < 500) begin
            step();
            c++;
        end
        chk("timeout_rx", int'(c < 500), 1);
    endtask

    function automatic logic [255:0] init_board();
        logic [255:0] b;
        logic [3:0] back [8];
        back = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
        b = '0;
        for (int f = 0; f < 8; f++) begin
            b[f*4 +: 4]      = 4'h8 | back[f];
            b[(8+f)*4 +: 4]  = 4'h9;
            b[(48+f)*4 +: 4] = 4'h1;
            b[(56+f)*4 +: 4] = back[f];
        end
        return b;
    endfunction

    task automatic check_initial_text();
        string lines [8];
        string s;
        lines = '{"rnbqkbnr", "pppppppp", "........", "........",
                  "........", "........", "PPPPPPPP", "RNBQKBNR"};
        chk("byte_count", rx_cnt[0], 80);
        chk("done_count", done_cnt[0], 1);
        for (int l = 0; l < 8; l++) begin
            s = lines[l];
            for (int f = 0; f < 8; f++)
                chk("text_char", int'(rx[0][l*10+f]), int'(s[f]));
            chk("text_cr", int'(rx[0][l*10+8]), 8'h0D);
            chk("text_lf", int'(rx[0][l*10+9]), 8'h0A);
        end
    endtask

    initial begin
        int crs;
        RESET_N  = 1'b0;
        BOARD    = '0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        rdy[0]   = 1'b1;
        rdy[1]   = 1'b1;
        step();
        step();
        chk("rst_data", int'(d_data[0]), 0);
        chk("rst_valid", int'(d_valid[0]), 0);
        chk("rst_busy", int'(d_busy[0]), 0);
        chk("rst_done", int'(d_done[0]), 0);
        RESET_N = 1'b1;
        step();

        // initial position, no backpressure
        BOARD = init_board();
        pulse_start(0);
        chk("first_byte", int'(d_data[0]), 8'h72);
        run_until_idle(0, 1'b0);
        check_initial_text();

        // random backpressure
        pulse_start(0);
        run_until_idle(0, 1'b1);
        check_initial_text();

        // board altered after start: snapshot must hold
        pulse_start(0);
        step();
        BOARD[52*4 +: 4] = 4'h0;
        run_until_idle(0, 1'b0);
        chk("snapshot_sq52", int'(rx[0][6*10+4]), 8'h50);
        chk("snap_count", rx_cnt[0], 80);
        BOARD = init_board();

        // START mid-dump and on the final-accept cycle
        pulse_start(0);
        wait_rx(0, 40);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        wait_rx(0, 79);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        run_until_idle(0, 1'b0);
        repeat (3) step();
        check_initial_text();

        // reset mid-dump
        pulse_start(0);
        wait_rx(0, 30);
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        chk("midrst_valid", int'(d_valid[0]), 0);
        chk("midrst_busy", int'(d_busy[0]), 0);
        chk("midrst_done", int'(d_done[0]), 0);
        repeat (2) step();
        chk("midrst_no_done", done_cnt[0], 0);
        pulse_start(0);
        run_until_idle(0, 1'b0);
        check_initial_text();

        // no-newline instance
        BOARD = '0;
        BOARD[3:0] = 4'hF;
        BOARD[7:4] = 4'h8;
        BOARD[63*4 +: 4] = 4'hE;
        pulse_start(1);
        run_until_idle(1, 1'b1);
        chk("nl0_count", rx_cnt[1], 64);
        chk("nl0_done", done_cnt[1], 1);
        chk("nl0_byte0", int'(rx[1][0]), 8'h3F);
        chk("nl0_byte1", int'(rx[1][1]), 8'h2E);
        chk("nl0_byte63", int'(rx[1][63]), 8'h6B);
        crs = 0;
        for (int i = 0; i < 64; i++)
            if (rx[1][i] == 8'h0D || rx[1][i] == 8'h0A) crs++;
        chk("nl0_no_crlf", crs, 0);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
